bus_arbiter_2m: RTL and testbench

Two-master arbiter for the 64-bit S64X7 system bus.
- Master 0 is the CPU, which drives instruction and data fetches with vpa_o and opc_o.
- Master 1 is a secondary bus master, such as DMA or a video fetcher.
- Round-robin arbitration; a grant is held for the whole bus cycle (cyc asserted).
- Granted master's signals are muxed onto the single slave port; ack is routed back to the granted master only.

---
 rtl/bus_arbiter_2m.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter_2m.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter for the 64-bit S64X7 bus (m0 = CPU, m1 = DMA/video); optional watchdog via `BUS_TIMEOUT_EN.
// Latency: grant one clock after a request is seen in IDLE; the granted master's request passes combinationally to the slave.
// Backpressure: grant held while owner's cyc is high, one dead IDLE cycle between owners; stalling masters is the system's job.
module bus_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADR_LSB        = 3
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [63:ADR_LSB]   m0_adr_i,
    input  logic                m0_cyc_i,
    input  logic [7:0]          m0_sel_i,
    input  logic                m0_we_i,
    input  logic                m0_vpa_i,
    input  logic [3:0]          m0_opc_i,
    input  logic [63:0]         m0_dat_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic [63:ADR_LSB]   m1_adr_i,
    input  logic                m1_cyc_i,
    input  logic [7:0]          m1_sel_i,
    input  logic                m1_we_i,
    input  logic [63:0]         m1_dat_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [63:ADR_LSB]   s_adr_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic [7:0]          s_sel_o,
    output logic                s_we_o,
    output logic                s_vpa_o,
    output logic [3:0]          s_opc_o,
    output logic [63:0]         s_dat_o,
    input  logic [63:0]         s_dat_i,
    input  logic                s_ack_i,
    output logic [1:0]          gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state_q;
    logic       last_q;     // master that owned the bus most recently
    logic [1:0] gnt_q;
    logic       own0;
    logic       own1;
    logic       timeout;    // terminal watchdog cycle: error instead of ack, grant dropped

    assign own0 = (state_q == GNT0);
    assign own1 = (state_q == GNT1);

    // Read data reaches both masters by direct wiring of the shared slave data net.
    logic unused_rdata;
    assign unused_rdata = ^s_dat_i;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt_q;

    // Count consecutive granted cycles without ack; held at zero while idle so each grant starts fresh
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= 16'd0;
        end else if ((state_q == IDLE) || s_ack_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // An ack in the terminal cycle wins over the error
    assign timeout = (own0 || own1) && !s_ack_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;

    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Arbitration FSM: choose an owner from IDLE, hold it until its cyc drops or the watchdog fires
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    // m0 wins when alone, or on a tie when m1 owned last
                    if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                        state_q <= GNT0;
                        gnt_q   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_q <= GNT1;
                        gnt_q   <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i || timeout) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        last_q  <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i || timeout) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        last_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Route the owner's request to the slave and the slave's ack back to the owner only
    always_comb begin
        s_cyc_o  = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = 8'h00;
        s_we_o   = 1'b0;
        s_vpa_o  = 1'b0;
        s_opc_o  = 4'h0;
        s_dat_o  = 64'h0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i && !timeout;
            s_adr_o  = m0_adr_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_vpa_o  = m0_vpa_i;
            s_opc_o  = m0_opc_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i && !timeout;
            s_adr_o  = m1_adr_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
        end
    end

    assign s_stb_o  = s_cyc_o;
    assign m0_err_o = own0 && timeout;
    assign m1_err_o = own1 && timeout;
    assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Self-checking bench for bus_arbiter_2m: directed scenarios plus randomized traffic against an ownership model.
// Latency: outputs sampled on the falling edge; inputs driven 1 ns after the rising edge.
// Backpressure: waits on grants are bounded; an expired wait is reported as a failed comparison.
module tb_bus_arbiter_2m;

    localparam int ALSB = 3;
    localparam int TO   = 4;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic [63:ALSB]    m0_adr_i, m1_adr_i, s_adr_o;
    logic              m0_cyc_i, m1_cyc_i, m0_we_i, m1_we_i, m0_vpa_i;
    logic [7:0]        m0_sel_i, m1_sel_i, s_sel_o;
    logic [3:0]        m0_opc_i, s_opc_o;
    logic [63:0]       m0_dat_i, m1_dat_i, s_dat_o, s_dat_i;
    logic              m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic              s_cyc_o, s_stb_o, s_we_o, s_vpa_o, s_ack_i;
    logic [1:0]        gnt_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the bus (-1 nobody), who owned it last, no-ack run length
    int own  = -1;
    int last = 1;
    int run  = 0;

    always #5 clk_i = ~clk_i;

    bus_arbiter_2m #(.TIMEOUT_CYCLES(TO), .ADR_LSB(ALSB)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_vpa_i(m0_vpa_i), .m0_opc_i(m0_opc_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_vpa_o(s_vpa_o), .s_opc_o(s_opc_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // True in the cycle where the owner has gone TO granted cycles in a row without ack
    function automatic bit term_now();
`ifdef BUS_TIMEOUT_EN
        return (own >= 0) && !s_ack_i && (run + 1 == TO);
`else
        return 1'b0;
`endif
    endfunction

    // Model: update ownership on each rising edge, drop everything on asynchronous reset
    always @(posedge clk_i or negedge reset_ni) begin
        bit t, rq;
        if (!reset_ni) begin
            own = -1; last = 1; run = 0;
        end else begin
            t = term_now();
            if (own < 0) begin
                run = 0;
                if (m0_cyc_i && m1_cyc_i) own = 1 - last;
                else if (m0_cyc_i)        own = 0;
                else if (m1_cyc_i)        own = 1;
            end else begin
                rq = (own == 0) ? m0_cyc_i : m1_cyc_i;
                if (t || !rq) begin
                    last = own;
                    own  = -1;
                end else if (s_ack_i) run = 0;
                else run++;
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk_i) begin
        bit t;
        logic [15:0] e_ctl;
        logic [63:ALSB] e_adr;
        logic [63:0] e_dat;
        logic [3:0] e_ae;
        logic [1:0] e_gnt;
        t = term_now();
        e_gnt = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        if (own == 0) begin
            e_ctl = {m0_cyc_i & ~t, m0_cyc_i & ~t, m0_we_i, m0_sel_i, m0_vpa_i, m0_opc_i};
            e_adr = m0_adr_i; e_dat = m0_dat_i;
        end else if (own == 1) begin
            e_ctl = {m1_cyc_i & ~t, m1_cyc_i & ~t, m1_we_i, m1_sel_i, 1'b0, 4'h0};
            e_adr = m1_adr_i; e_dat = m1_dat_i;
        end else begin
            e_ctl = 16'h0; e_adr = '0; e_dat = 64'h0;
        end
        e_ae = {(own == 0) && s_ack_i, (own == 1) && s_ack_i, (own == 0) && t, (own == 1) && t};
        chk("cmp_ctl", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_vpa_o, s_opc_o}), 128'(e_ctl));
        chk("cmp_adr", 128'(s_adr_o), 128'(e_adr));
        chk("cmp_dat", 128'(s_dat_o), 128'(e_dat));
        chk("cmp_ack_err", 128'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 128'(e_ae));
        chk("cmp_gnt", 128'(gnt_o), 128'(e_gnt));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called on a falling edge; waits (bounded) until gnt_o is non-zero
    task automatic wait_any_gnt(input string name, input logic [1:0] want);
        int n = 0;
        while (gnt_o == 2'b00 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, 128'(gnt_o), 128'(want));
    endtask

    task automatic wait_gnt(input string name, input logic [1:0] want);
        int n = 0;
        while (gnt_o !== want && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, 128'(gnt_o), 128'(want));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [63:0] r64;
        logic [1:0]  exp_g;
        reset_ni = 1'b0;
        m0_adr_i = '0; m1_adr_i = '0; m0_sel_i = 8'h0; m1_sel_i = 8'h0;
        m0_we_i = 1'b0; m1_we_i = 1'b0; m0_vpa_i = 1'b0; m0_opc_i = 4'h0;
        m0_dat_i = 64'h0; m1_dat_i = 64'h0; s_dat_i = 64'h0; s_ack_i = 1'b0;
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;

        // Reset held with both requesting: nothing reaches the slave
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_s_cyc", 128'(s_cyc_o), 128'(0));
        chk("rst_gnt", 128'(gnt_o), 128'(0));
        tick();
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("tie_idle_gnt", 128'(gnt_o), 128'(2'b00));
        @(negedge clk_i);
        chk("tie_first_gnt", 128'(gnt_o), 128'(2'b01));
        tick();
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        tick();

        // m0 write, slave acks in the second granted cycle
        m0_adr_i = 61'h1; m0_sel_i = 8'h0F; m0_dat_i = 64'hDEAD_BEEF; m0_we_i = 1'b1; m0_cyc_i = 1'b1;
        @(negedge clk_i);
        chk("wr_idle_cyc", 128'(s_cyc_o), 128'(0));
        tick();
        @(negedge clk_i);
        chk("wr_gnt", 128'(gnt_o), 128'(2'b01));
        chk("wr_s_bus", 128'({s_cyc_o, s_we_o, s_sel_o}), 128'({1'b1, 1'b1, 8'h0F}));
        chk("wr_s_adr", 128'(s_adr_o), 128'(1));
        chk("wr_s_dat", 128'(s_dat_o), 128'(64'hDEAD_BEEF));
        tick();
        s_ack_i = 1'b1;
        @(negedge clk_i);
        chk("wr_acks", 128'({m0_ack_o, m1_ack_o}), 128'(2'b10));
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_we_i = 1'b0;
        @(negedge clk_i);
        chk("wr_rel_cyc_ack", 128'({s_cyc_o, m0_ack_o, gnt_o}), 128'({1'b0, 1'b0, 2'b01}));
        tick();
        @(negedge clk_i);
        chk("wr_after_gnt", 128'(gnt_o), 128'(2'b00));

        // Both requesting: m0 just owned, so m1 first, then strict alternation with a dead cycle
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_g = (t % 2 == 0) ? 2'b10 : 2'b01;
            wait_any_gnt("alt_owner", exp_g);
            tick();
            s_ack_i = 1'b1;
            tick();
            s_ack_i = 1'b0;
            if (exp_g == 2'b10) m1_cyc_i = 1'b0; else m0_cyc_i = 1'b0;
            @(negedge clk_i);
            tick();
            m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
            @(negedge clk_i);
            chk("alt_dead", 128'(gnt_o), 128'(0));
        end
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        tick();

        // CPU fetch qualifiers pass only while m0 owns the bus
        m0_cyc_i = 1'b1; m0_vpa_i = 1'b1; m0_opc_i = 4'h3;
        @(negedge clk_i);
        wait_gnt("vpa_gnt0", 2'b01);
        chk("vpa_m0", 128'({s_vpa_o, s_opc_o}), 128'({1'b1, 4'h3}));
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b1;
        @(negedge clk_i);
        wait_gnt("vpa_gnt1", 2'b10);
        chk("vpa_m1", 128'({s_vpa_o, s_opc_o}), 128'(0));

        // Reset pulled low mid-cycle while m1 owns the bus and the slave acks
        chk("prerst_cyc", 128'(s_cyc_o), 128'(1));
        #2;
        s_ack_i = 1'b1; reset_ni = 1'b0;
        #1;
        chk("midrst", 128'({s_cyc_o, gnt_o, m1_ack_o, m0_ack_o}), 128'(0));
        tick();
        s_ack_i = 1'b0; reset_ni = 1'b1;
        m0_vpa_i = 1'b0; m0_opc_i = 4'h0;
        @(negedge clk_i);
        chk("postrst_idle", 128'(gnt_o), 128'(0));

        // m1 alone, slave silent
`ifdef BUS_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk_i);
            chk("to_err", 128'({m1_err_o, s_cyc_o}), 128'({k == TO, k != TO}));
        end
        m0_cyc_i = 1'b1;
        @(negedge clk_i);
        chk("to_idle", 128'({gnt_o, m1_err_o}), 128'(0));
        @(negedge clk_i);
        chk("to_tie_m0", 128'(gnt_o), 128'(2'b01));
`else
        repeat (10) @(negedge clk_i);
        chk("hold_m1", 128'({gnt_o, m1_err_o, s_cyc_o}), 128'({2'b10, 1'b0, 1'b1}));
`endif
        tick();
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        tick();

        // Randomized traffic; the falling-edge compare checks every cycle
        for (int c = 0; c < 1500; c++) begin
            if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 5) != 0);
            else          m0_cyc_i = ($urandom_range(0, 2) == 0);
            if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 5) != 0);
            else          m1_cyc_i = ($urandom_range(0, 2) == 0);
            s_ack_i  = ($urandom_range(0, 3) == 0);
            r64 = {$urandom, $urandom}; m0_adr_i = r64[63:ALSB];
            r64 = {$urandom, $urandom}; m1_adr_i = r64[63:ALSB];
            m0_dat_i = {$urandom, $urandom};
            m1_dat_i = {$urandom, $urandom};
            s_dat_i  = {$urandom, $urandom};
            m0_sel_i = 8'($urandom); m1_sel_i = 8'($urandom);
            m0_we_i  = 1'($urandom); m1_we_i  = 1'($urandom);
            m0_vpa_i = 1'($urandom); m0_opc_i = 4'($urandom);
            tick();
        end

        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
